dcmac_0_axis_pkt_mon_dat_pack: RTL

DCMAC_0_AXIS_PKT_MON_DAT_PACK -- requirements
Module: dcmac_0_axis_pkt_mon_dat_pack

---
 rtl/dcmac_0_axis_pkt_mon_pkg.sv | 38 +++
 rtl/dcmac_0_axis_pkt_mon_pack_ctx.sv | 51 +++++
 rtl/dcmac_0_axis_pkt_mon_dat_pack.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dcmac_0_axis_pkt_mon_pkg.sv
// Shared widths, fragment/word bundles and byte masking for the packet-monitor data packer.
package dcmac_0_axis_pkt_mon_pkg;
   localparam int WORD_BYTES = 192;
   localparam int CNT_W      = 8;
   localparam int ID_W       = 3;
   localparam int LAT        = 2;

   localparam logic [CNT_W:0] TOT_FULL = (CNT_W+1)'(WORD_BYTES);

   typedef logic [WORD_BYTES-1:0][7:0] word_dat_t;
   typedef logic [WORD_BYTES-2:0][7:0] res_dat_t;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [CNT_W-1:0] cnt;
      logic             eop;
      word_dat_t        dat;
   } frag_t;

   typedef struct packed {
      logic             vld;
      logic [ID_W-1:0]  id;
      logic [CNT_W-1:0] cnt;
      logic             eop;
      word_dat_t        dat;
   } word_t;

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   // Zero every byte at index >= n.
   function automatic word_dat_t keep_bytes(input word_dat_t d, input logic [CNT_W:0] n);
      word_dat_t m;
      m = '0;
      for (int i = 0; i < WORD_BYTES; i++)
         if (i < int'(n)) m[i] = d[i];
      return m;
   endfunction
endpackage

// File: rtl/dcmac_0_axis_pkt_mon_pack_ctx.sv
// Per-channel fill level and residue bytes; the read port sees a same-cycle write to that channel.
module dcmac_0_axis_pkt_mon_pack_ctx
   import dcmac_0_axis_pkt_mon_pkg::*;
#(
   parameter int NCH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ID_W-1:0]  i_rd_id,
   output logic [CNT_W-1:0] o_rd_fill,
   output res_dat_t         o_rd_res,
   input  logic             i_wr_en,
   input  logic [ID_W-1:0]  i_wr_id,
   input  logic [CNT_W-1:0] i_wr_fill,
   input  res_dat_t         i_wr_res
);
   logic [CNT_W-1:0] r_fill [NCH];
   res_dat_t         r_res  [NCH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NCH; c++) r_fill[c] <= '0;
      end else if (i_wr_en) begin
         for (int c = 0; c < NCH; c++)
            if (i_wr_id == ID_W'(c)) r_fill[c] <= i_wr_fill;
      end
   end

   // Residue bytes are only meaningful below the fill level, so they need no reset.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         for (int c = 0; c < NCH; c++)
            if (i_wr_id == ID_W'(c)) r_res[c] <= i_wr_res;
      end
   end

   always_comb begin
      o_rd_fill = '0;
      o_rd_res  = '0;
      for (int c = 0; c < NCH; c++) begin
         if (i_rd_id == ID_W'(c)) begin
            o_rd_fill = r_fill[c];
            o_rd_res  = r_res[c];
         end
      end
      if (i_wr_en && (i_wr_id == i_rd_id)) begin
         o_rd_fill = i_wr_fill;
         o_rd_res  = i_wr_res;
      end
   end
endmodule

// File: rtl/dcmac_0_axis_pkt_mon_dat_pack.sv
// Packs variable-size per-channel fragments into 192-byte words; two-cycle pipeline plus one flush cycle.
module dcmac_0_axis_pkt_mon_dat_pack
   import dcmac_0_axis_pkt_mon_pkg::*;
#(
   parameter int NCH = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_vld,
   input  logic [ID_W-1:0]            i_id,
   input  logic [CNT_W-1:0]           i_cnt,
   input  logic                       i_eop,
   input  logic [WORD_BYTES-1:0][7:0] i_dat,
   output logic                       o_rdy,
   output logic                       o_vld,
   output logic [ID_W-1:0]            o_id,
   output logic [CNT_W-1:0]           o_cnt,
   output logic                       o_eop,
   output logic [WORD_BYTES-1:0][7:0] o_dat,
   output logic                       o_err
);
   state_t           r_state, w_state_nxt;
   logic             r_live;
   frag_t            w_in;
   logic             w_acc, w_bad, w_ok, w_err, w_go_flush;
   logic [CNT_W-1:0] w_rd_fill;
   res_dat_t         w_rd_res;
   logic [CNT_W:0]   w_tot;

   logic             r_s1_vld, r_s1_eop;
   logic [ID_W-1:0]  r_s1_id;
   logic [CNT_W-1:0] r_s1_fill;
   logic [CNT_W:0]   r_s1_tot;
   word_dat_t        r_s1_frag;
   res_dat_t         r_s1_res;
   logic [LAT-1:0]   r_err_pipe;
   word_t            r_fl, r_out;

   logic [2*WORD_BYTES-2:0][7:0] w_lo, w_sh, w_comb;
   logic             w_full, w_over, w_emit, w_last;
   logic [CNT_W-1:0] w_rem, w_wcnt, w_wr_fill;
   word_dat_t        w_wdat;
   res_dat_t         w_wr_res;

   assign w_in  = {i_id, i_cnt, i_eop, i_dat};
   assign o_rdy = r_live & (r_state == ST_RUN);
   assign w_acc = i_vld & o_rdy;
   assign w_bad = (int'(w_in.id) >= NCH) | (w_in.cnt == '0) | ({1'b0, w_in.cnt} > TOT_FULL);
   assign w_ok  = w_acc & ~w_bad;
   assign w_err = w_acc & w_bad;
   assign w_tot = {1'b0, w_rd_fill} + {1'b0, w_in.cnt};
   assign w_go_flush = w_ok & w_in.eop & (w_tot > TOT_FULL);

   dcmac_0_axis_pkt_mon_pack_ctx #(.NCH(NCH)) u_ctx (
      .clk       (clk),
      .rst       (rst),
      .i_rd_id   (w_in.id),
      .o_rd_fill (w_rd_fill),
      .o_rd_res  (w_rd_res),
      .i_wr_en   (r_s1_vld),
      .i_wr_id   (r_s1_id),
      .i_wr_fill (w_wr_fill),
      .i_wr_res  (w_wr_res)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_RUN;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_live  <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:   if (w_go_flush) w_state_nxt = ST_FLUSH;
         ST_FLUSH: w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

   // Merge window: live residue bytes, then the fragment shifted up behind them.
   always_comb begin
      w_lo = '0;
      w_lo[WORD_BYTES-1:0] = keep_bytes({8'h00, r_s1_res}, {1'b0, r_s1_fill});
      w_sh = '0;
      w_sh[WORD_BYTES-1:0] = r_s1_frag;
      w_sh   = w_sh << {r_s1_fill, 3'b000};
      w_comb = w_lo | w_sh;
   end

   assign w_full    = r_s1_tot >= TOT_FULL;
   assign w_over    = r_s1_tot > TOT_FULL;
   assign w_emit    = r_s1_vld & (w_full | r_s1_eop);
   assign w_last    = r_s1_eop & ~w_over;
   assign w_rem     = r_s1_tot[CNT_W-1:0] - TOT_FULL[CNT_W-1:0];
   assign w_wcnt    = w_full ? TOT_FULL[CNT_W-1:0] : r_s1_tot[CNT_W-1:0];
   assign w_wdat    = keep_bytes(w_comb[WORD_BYTES-1:0], {1'b0, w_wcnt});
   assign w_wr_fill = r_s1_eop ? '0 : (w_full ? w_rem : r_s1_tot[CNT_W-1:0]);
   assign w_wr_res  = w_full ? w_comb[2*WORD_BYTES-2:WORD_BYTES] : w_comb[WORD_BYTES-2:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_vld   <= 1'b0;
         r_s1_eop   <= 1'b0;
         r_s1_id    <= '0;
         r_s1_fill  <= '0;
         r_s1_tot   <= '0;
         r_s1_frag  <= '0;
         r_s1_res   <= '0;
         r_err_pipe <= '0;
         r_fl       <= '0;
         r_out      <= '0;
      end else begin
         r_s1_vld   <= w_ok;
         r_s1_eop   <= w_in.eop;
         r_s1_id    <= w_in.id;
         r_s1_fill  <= w_rd_fill;
         r_s1_tot   <= w_tot;
         r_s1_frag  <= keep_bytes(w_in.dat, {1'b0, w_in.cnt});
         r_s1_res   <= w_rd_res;
         r_err_pipe <= {r_err_pipe[LAT-2:0], w_err};
         r_fl       <= {r_s1_vld & r_s1_eop & w_over, r_s1_id, w_rem, 1'b1,
                        {8'h00, w_comb[2*WORD_BYTES-2:WORD_BYTES]}};
         // The flush word never collides: o_rdy was low the cycle before it.
         if (w_emit)        r_out <= {1'b1, r_s1_id, w_wcnt, w_last, w_wdat};
         else if (r_fl.vld) r_out <= r_fl;
         else               r_out <= '0;
      end
   end

   assign o_vld = r_out.vld;
   assign o_id  = r_out.id;
   assign o_cnt = r_out.cnt;
   assign o_eop = r_out.eop;
   assign o_dat = r_out.dat;
   assign o_err = r_err_pipe[LAT-1];
endmodule
